// File: rtl/noc_local_rx_parser.sv
// Tile-local NoC receive parser: turns write packets into scratchpad word writes,
// read packets into read-request descriptors, and drains/counts malformed packets.
module noc_local_rx_parser #(
  parameter int BW        = 32,
  parameter int BWB       = BW / 8,
  parameter int XY_SZ     = 3,
  parameter int OFFSET_SZ = 12,
  parameter int LEN_SZ    = 10,
  parameter int ERR_CNT_W = 16
) (
  input  logic                   clk_line,
  input  logic                   clk_line_rst_high,
  input  logic [2*XY_SZ-1:0]     HsrcId,
  input  logic                   stream_in_TVALID,
  input  logic [BW-1:0]          stream_in_TDATA,
  input  logic [BWB-1:0]         stream_in_TKEEP,
  input  logic                   stream_in_TLAST,
  output logic                   stream_in_TREADY,
  output logic                   mem_wr_en,
  output logic [OFFSET_SZ-1:0]   mem_wr_addr,
  output logic [BW-1:0]          mem_wr_data,
  output logic [BWB-1:0]         mem_wr_strb,
  output logic                   rd_req_TVALID,
  input  logic                   rd_req_TREADY,
  output logic [2*XY_SZ-1:0]     rd_req_src,
  output logic [OFFSET_SZ-1:0]   rd_req_offset,
  output logic [LEN_SZ-1:0]      rd_req_len,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_OFS  = 3'd1,
    S_DATA = 3'd2,
    S_DROP = 3'd3,
    S_REQ  = 3'd4
  } state_t;

  localparam int SRC_LO = 2 * XY_SZ;
  localparam int OP_LO  = 4 * XY_SZ;
  localparam int LEN_LO = OP_LO + 2;

  state_t                 state_q, state_d;
  logic                   tready_q;
  logic                   busy_q;
  logic                   rd_valid_q;
  logic [2*XY_SZ-1:0]     src_q;
  logic [1:0]             op_q;
  logic [LEN_SZ-1:0]      len_q;
  logic [LEN_SZ-1:0]      rem_q;
  logic [OFFSET_SZ-1:0]   addr_q;
  logic [ERR_CNT_W-1:0]   err_q;
  logic                   wr_en_q;
  logic [OFFSET_SZ-1:0]   wr_addr_q;
  logic [BW-1:0]          wr_data_q;
  logic [BWB-1:0]         wr_strb_q;

  logic                   hs_s;
  logic                   err_s;
  logic [2*XY_SZ-1:0]     hdr_dest_s;
  logic [1:0]             hdr_op_s;

  assign hs_s       = stream_in_TVALID && tready_q;
  assign hdr_dest_s = stream_in_TDATA[2*XY_SZ-1:0];
  assign hdr_op_s   = stream_in_TDATA[OP_LO+1:OP_LO];

  // Next-state and error-detection decode
  always_comb begin
    state_d = state_q;
    err_s   = 1'b0;
    case (state_q)
      S_HDR: begin
        if (hs_s) begin
          if ((hdr_dest_s != HsrcId) || hdr_op_s[1] || stream_in_TLAST) begin
            err_s   = 1'b1;
            state_d = stream_in_TLAST ? S_HDR : S_DROP;
          end else begin
            state_d = S_OFS;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_OFS: begin
        if (hs_s) begin
          if (op_q == 2'b00) begin
            if (len_q == LEN_SZ'(0)) begin
              err_s   = !stream_in_TLAST;
              state_d = stream_in_TLAST ? S_HDR : S_DROP;
            end else begin
              err_s   = stream_in_TLAST;
              state_d = stream_in_TLAST ? S_HDR : S_DATA;
            end
          end else begin
            err_s   = !stream_in_TLAST;
            state_d = stream_in_TLAST ? S_REQ : S_DROP;
          end
        end else begin
          state_d = S_OFS;
        end
      end
      S_DATA: begin
        if (hs_s) begin
          if (rem_q == LEN_SZ'(1)) begin
            err_s   = !stream_in_TLAST;
            state_d = stream_in_TLAST ? S_HDR : S_DROP;
          end else begin
            // early TLAST: words already written are kept
            err_s   = stream_in_TLAST;
            state_d = stream_in_TLAST ? S_HDR : S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_DROP: begin
        if (hs_s && stream_in_TLAST) begin
          state_d = S_HDR;
        end else begin
          state_d = S_DROP;
        end
      end
      S_REQ: begin
        if (rd_valid_q && rd_req_TREADY) begin
          state_d = S_HDR;
        end else begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // State, registered outputs, latched packet fields and error counter
  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      state_q    <= S_HDR;
      tready_q   <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      src_q      <= '0;
      op_q       <= 2'b00;
      len_q      <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      err_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      state_q    <= state_d;
      tready_q   <= (state_d != S_REQ);
      busy_q     <= (state_d != S_HDR);
      rd_valid_q <= (state_d == S_REQ);
      wr_en_q    <= 1'b0;
      if (err_s && (err_q != {ERR_CNT_W{1'b1}})) begin
        err_q <= err_q + ERR_CNT_W'(1);
      end
      if (hs_s) begin
        case (state_q)
          S_HDR: begin
            src_q <= stream_in_TDATA[SRC_LO+2*XY_SZ-1:SRC_LO];
            op_q  <= hdr_op_s;
            len_q <= stream_in_TDATA[LEN_LO+LEN_SZ-1:LEN_LO];
          end
          S_OFS: begin
            addr_q <= stream_in_TDATA[OFFSET_SZ-1:0];
            rem_q  <= len_q;
          end
          S_DATA: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= stream_in_TDATA;
            wr_strb_q <= stream_in_TKEEP;
            addr_q    <= addr_q + OFFSET_SZ'(1);
            rem_q     <= rem_q - LEN_SZ'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign stream_in_TREADY = tready_q;
  assign busy             = busy_q;
  assign rd_req_TVALID    = rd_valid_q;
  assign rd_req_src       = src_q;
  assign rd_req_offset    = addr_q;
  assign rd_req_len       = len_q;
  assign err_count        = err_q;
  assign mem_wr_en        = wr_en_q;
  assign mem_wr_addr      = wr_addr_q;
  assign mem_wr_data      = wr_data_q;
  assign mem_wr_strb      = wr_strb_q;

endmodule

// File: tb/tb_noc_local_rx_parser.sv
// Directed bench for noc_local_rx_parser with hand-computed expected values.
module tb_noc_local_rx_parser;

  logic        clk;
  logic        rst;
  logic [5:0]  hsrc;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rq_valid;
  logic        rq_ready;
  logic [5:0]  rq_src;
  logic [11:0] rq_ofs;
  logic [9:0]  rq_len;
  logic [15:0] err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  noc_local_rx_parser dut (
    .clk_line          (clk),
    .clk_line_rst_high (rst),
    .HsrcId            (hsrc),
    .stream_in_TVALID  (tvalid),
    .stream_in_TDATA   (tdata),
    .stream_in_TKEEP   (tkeep),
    .stream_in_TLAST   (tlast),
    .stream_in_TREADY  (tready),
    .mem_wr_en         (wr_en),
    .mem_wr_addr       (wr_addr),
    .mem_wr_data       (wr_data),
    .mem_wr_strb       (wr_strb),
    .rd_req_TVALID     (rq_valid),
    .rd_req_TREADY     (rq_ready),
    .rd_req_src        (rq_src),
    .rd_req_offset     (rq_ofs),
    .rd_req_len        (rq_len),
    .err_count         (err_cnt),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hdr(input logic [5:0] dst, input logic [5:0] src,
                                      input logic [1:0] op, input logic [9:0] len);
    return {8'h00, len, op, src, dst};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one flit, waiting (bounded) for TREADY; returns #1 after the handshake edge.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_timeout", 64'(n < 100), 64'd1);
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = last;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    chk({tag, "_en"},   64'(wr_en),   64'd1);
    chk({tag, "_addr"}, 64'(wr_addr), 64'(a));
    chk({tag, "_data"}, 64'(wr_data), 64'(d));
    chk({tag, "_strb"}, 64'(wr_strb), 64'(s));
  endtask

  initial begin
    rst      = 1'b1;
    hsrc     = 6'h0A;
    tvalid   = 1'b0;
    tdata    = 32'h0;
    tkeep    = 4'h0;
    tlast    = 1'b0;
    rq_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", 64'(tready),   64'd0);
    chk("rst_busy",   64'(busy),     64'd0);
    chk("rst_wr_en",  64'(wr_en),    64'd0);
    chk("rst_rq_vld", 64'(rq_valid), 64'd0);
    chk("rst_err",    64'(err_cnt),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_tready", 64'(tready), 64'd1);

    // write len=3 at 0x0FE crossing 0x100
    send(hdr(6'h0A, 6'h11, 2'b00, 10'd3), 4'hF, 1'b0);
    chk("w1_busy_hdr", 64'(busy), 64'd1);
    send(32'h0000_00FE, 4'hF, 1'b0);
    send(32'hA0A0_A0A0, 4'hF, 1'b0);
    chk_wr("w1_a0", 12'h0FE, 32'hA0A0_A0A0, 4'hF);
    send(32'hA1A1_A1A1, 4'h3, 1'b0);
    chk_wr("w1_a1", 12'h0FF, 32'hA1A1_A1A1, 4'h3);
    send(32'hA2A2_A2A2, 4'hC, 1'b1);
    chk_wr("w1_a2", 12'h100, 32'hA2A2_A2A2, 4'hC);
    chk("w1_busy_end", 64'(busy),    64'd0);
    chk("w1_err",      64'(err_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk("w1_wr_pulse", 64'(wr_en), 64'd0);

    // write len=2 at 0xFFF wraps to 0x000
    send(hdr(6'h0A, 6'h11, 2'b00, 10'd2), 4'hF, 1'b0);
    send(32'hFFFF_FFFF, 4'hF, 1'b0);
    send(32'hB0B0_B0B0, 4'hF, 1'b0);
    chk_wr("w2_b0", 12'hFFF, 32'hB0B0_B0B0, 4'hF);
    send(32'hB1B1_B1B1, 4'hF, 1'b1);
    chk_wr("w2_b1", 12'h000, 32'hB1B1_B1B1, 4'hF);

    // read len=8 at 0x020, descriptor held off for 5 cycles
    send(hdr(6'h0A, 6'h11, 2'b01, 10'd8), 4'hF, 1'b0);
    send(32'h0000_0020, 4'hF, 1'b1);
    chk("rd_valid_rise", 64'(rq_valid), 64'd1);
    chk("rd_tready_low", 64'(tready),   64'd0);
    tvalid = 1'b1;
    tdata  = hdr(6'h0A, 6'h11, 2'b00, 10'd1);
    tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rd_hold_valid",  64'(rq_valid), 64'd1);
      chk("rd_hold_tready", 64'(tready),   64'd0);
      chk("rd_hold_src",    64'(rq_src),   64'h11);
      chk("rd_hold_ofs",    64'(rq_ofs),   64'h020);
      chk("rd_hold_len",    64'(rq_len),   64'd8);
    end
    @(negedge clk);
    rq_ready = 1'b1;
    @(posedge clk);
    #1;
    rq_ready = 1'b0;
    chk("rd_valid_fall", 64'(rq_valid), 64'd0);
    chk("rd_tready_back", 64'(tready),  64'd1);
    chk("rd_hdr_not_taken", 64'(busy),  64'd0);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    chk("rd_next_hdr_taken", 64'(busy), 64'd1);
    send(32'h0000_0055, 4'hF, 1'b0);
    send(32'hC0C0_C0C0, 4'hF, 1'b1);
    chk_wr("rd_next_c0", 12'h055, 32'hC0C0_C0C0, 4'hF);
    chk("rd_err", 64'(err_cnt), 64'd0);

    // misrouted 4-flit packet is drained
    send(hdr(6'h0B, 6'h11, 2'b00, 10'd2), 4'hF, 1'b0);
    chk("mis_err_at_hdr", 64'(err_cnt), 64'd1);
    send(32'h0000_0010, 4'hF, 1'b0);
    chk("mis_no_wr1", 64'(wr_en), 64'd0);
    send(32'hDEAD_0001, 4'hF, 1'b0);
    chk("mis_no_wr2", 64'(wr_en), 64'd0);
    send(32'hDEAD_0002, 4'hF, 1'b1);
    chk("mis_no_wr3", 64'(wr_en), 64'd0);
    chk("mis_busy",   64'(busy),  64'd0);
    chk("mis_err",    64'(err_cnt), 64'd1);
    send(hdr(6'h0A, 6'h11, 2'b00, 10'd1), 4'hF, 1'b0);
    send(32'h0000_0010, 4'hF, 1'b0);
    send(32'hD0D0_D0D0, 4'h5, 1'b1);
    chk_wr("mis_next_d0", 12'h010, 32'hD0D0_D0D0, 4'h5);

    // len=4 with early TLAST on data 2
    send(hdr(6'h0A, 6'h11, 2'b00, 10'd4), 4'hF, 1'b0);
    send(32'h0000_0200, 4'hF, 1'b0);
    send(32'h2222_0000, 4'hF, 1'b0);
    chk_wr("short_w0", 12'h200, 32'h2222_0000, 4'hF);
    send(32'h2222_0001, 4'hF, 1'b1);
    chk_wr("short_w1", 12'h201, 32'h2222_0001, 4'hF);
    chk("short_err",  64'(err_cnt), 64'd2);
    chk("short_busy", 64'(busy),    64'd0);

    // len=1 with TLAST two flits late
    send(hdr(6'h0A, 6'h11, 2'b00, 10'd1), 4'hF, 1'b0);
    send(32'h0000_0300, 4'hF, 1'b0);
    send(32'hE0E0_E0E0, 4'hF, 1'b0);
    chk_wr("long_e0", 12'h300, 32'hE0E0_E0E0, 4'hF);
    chk("long_err", 64'(err_cnt), 64'd3);
    send(32'hE1E1_E1E1, 4'hF, 1'b0);
    chk("long_no_wr1", 64'(wr_en), 64'd0);
    send(32'hE2E2_E2E2, 4'hF, 1'b1);
    chk("long_no_wr2", 64'(wr_en), 64'd0);
    chk("long_busy",   64'(busy),  64'd0);
    chk("long_err_end", 64'(err_cnt), 64'd3);

    // reserved opcode
    send(hdr(6'h0A, 6'h11, 2'b10, 10'd0), 4'hF, 1'b0);
    send(32'h0000_0001, 4'hF, 1'b1);
    chk("rsvd_err", 64'(err_cnt), 64'd4);
    chk("rsvd_no_wr", 64'(wr_en), 64'd0);

    // reset mid-DATA, then a fresh packet
    send(hdr(6'h0A, 6'h11, 2'b00, 10'd3), 4'hF, 1'b0);
    send(32'h0000_0400, 4'hF, 1'b0);
    send(32'hF0F0_F0F0, 4'hF, 1'b0);
    chk_wr("mid_f0", 12'h400, 32'hF0F0_F0F0, 4'hF);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en",  64'(wr_en),    64'd0);
    chk("mid_rst_tready", 64'(tready),   64'd0);
    chk("mid_rst_busy",   64'(busy),     64'd0);
    chk("mid_rst_err",    64'(err_cnt),  64'd0);
    chk("mid_rst_addr",   64'(wr_addr),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    send(hdr(6'h0A, 6'h11, 2'b00, 10'd2), 4'hF, 1'b0);
    send(32'h0000_0010, 4'hF, 1'b0);
    send(32'h1111_1111, 4'hF, 1'b0);
    chk_wr("fresh_w0", 12'h010, 32'h1111_1111, 4'hF);
    send(32'h2222_2222, 4'hF, 1'b1);
    chk_wr("fresh_w1", 12'h011, 32'h2222_2222, 4'hF);
    chk("fresh_err",  64'(err_cnt), 64'd0);
    chk("fresh_busy", 64'(busy),    64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_local_rx_parser.md
Name: noc_local_rx_parser

Overview:
- Consumes the packet stream from the tile switch local output port (stream_out_local_out_*) and decodes NoC packets addressed to this tile.
- Write packets become word writes on the scratchpad memory port.
- Read packets become read-request descriptors for the scratchpad's response generator.
- Sits between the tile switch and the scratchpad memory manager in the clk_line domain.
- Malformed or misrouted packets are drained and counted, never forwarded.

Parameters:
- BW, 32: stream data width in bits.
- BWB, BW/8: TKEEP / write-strobe width.
- XY_SZ, 3: width of each X/Y coordinate field.
- OFFSET_SZ, 12: scratchpad word-address width.
- LEN_SZ, 10: packet payload length field width, in words.
- ERR_CNT_W, 16: error counter width.

Ports:
- clk_line  in  1  line clock; all logic is clocked on the rising edge.
- clk_line_rst_high  in  1  asynchronous, active-high reset.
- HsrcId  in  2*XY_SZ  this tile's id {Y,X}; held static during operation.
- stream_in_TVALID  in  1  flit valid from switch local port.
- stream_in_TDATA  in  BW  flit data.
- stream_in_TKEEP  in  BWB  byte keep.
- stream_in_TLAST  in  1  last flit of packet.
- stream_in_TREADY  out  1  flit accept.
- mem_wr_en  out  1  one-cycle scratchpad write strobe.
- mem_wr_addr  out  OFFSET_SZ  word address.
- mem_wr_data  out  BW  write data.
- mem_wr_strb  out  BWB  byte enables (TKEEP of the data flit).
- rd_req_TVALID  out  1  read descriptor valid.
- rd_req_TREADY  in  1  read descriptor accept.
- rd_req_src  out  2*XY_SZ  requester id (reply destination).
- rd_req_offset  out  OFFSET_SZ  start word address.
- rd_req_len  out  LEN_SZ  word count.
- err_count  out  ERR_CNT_W  saturating count of dropped packets.
- busy  out  1  high in any state other than HDR.

Behaviour:
- Header flit layout (flit 0):
  - [2*XY_SZ-1:0] dest id.
  - [4*XY_SZ-1:2*XY_SZ] src id.
  - next 2 bits: opcode (00 write, 01 read, 1x reserved).
  - next LEN_SZ bits: length.
  - remaining bits ignored.
- Flit 1 carries the word offset in [OFFSET_SZ-1:0]; upper bits are ignored.
- Flit handshake: TVALID && TREADY on a rising edge. TDATA, TKEEP and TLAST are sampled only on a handshake.
- States:
  - HDR: TREADY=1. On handshake, latch src, opcode and len.
    - dest != HsrcId, opcode reserved, or TLAST=1 -> error; go to DROP, or stay in HDR if TLAST=1.
    - otherwise -> OFS.
  - OFS: TREADY=1. On handshake, latch offset into the address counter.
    - write with len=0: TLAST=1 -> HDR; TLAST=0 -> error, DROP.
    - write with len>0: TLAST=1 -> error, HDR; TLAST=0 -> DATA with remaining=len.
    - read: TLAST=1 -> REQ; TLAST=0 -> error, DROP.
  - DATA: TREADY=1. Each handshake issues one memory write; the address increments and wraps modulo 2^OFFSET_SZ; remaining decrements.
    - remaining==1 and TLAST=1 -> HDR.
    - remaining==1 and TLAST=0 -> error, DROP.
    - remaining>1 and TLAST=1 -> error, HDR (already-written words stand).
  - DROP: TREADY=1; discard flits until a TLAST handshake, then -> HDR.
  - REQ: TREADY=0. rd_req_TVALID=1 with src/offset/len stable.
    - On rd_req_TVALID && rd_req_TREADY -> HDR; TVALID drops the next cycle.
    - A pending request holds indefinitely while rd_req_TREADY=0.
- Write timing:
  - mem_wr_* are registered: asserted exactly 1 cycle after the data-flit handshake, for 1 cycle.
  - Back-to-back flits give back-to-back writes; the memory port has no backpressure.
- Read latency: rd_req_TVALID rises 1 cycle after the offset-flit handshake.
- Error counting:
  - err_count increments by 1 per offending packet, counted at detection time, and saturates at all-ones.
  - A packet that errs causes exactly one increment.
- TKEEP is ignored on header/offset flits.
- Reset (asynchronous, active-high):
  - state=HDR; all outputs 0 (TREADY=0 while reset is asserted, =1 after release).
  - err_count=0; all latched fields 0.
  - Reset mid-packet abandons the packet. Subsequent flits are parsed as a new header; there is no resynchronisation beyond that.

Test Plan:
- HsrcId=6'h0A; write packet: hdr dest=0x0A, src=0x11, op=00, len=3; offset 0x0FE; data A0,A1,A2 with TLAST on A2 -> writes (0x0FE,A0), (0x0FF,A1), (0x100,A2), each 1 cycle after its handshake; err_count=0.
- Write len=2 at offset 0xFFF -> addresses 0xFFF then 0x000 (wrap).
- Read packet: src=0x11, offset 0x020, len=8, TLAST on offset; hold rd_req_TREADY=0 for 5 cycles:
  - rd_req_TVALID=1 with fields stable; TREADY=0 throughout; a header presented meanwhile is not accepted.
  - On ready, one handshake, then the next packet is parsed.
- Dest=0x0B while HsrcId=0x0A, 4-flit packet -> no writes, all flits accepted, err_count=1, next valid packet processed normally.
- Length mismatches:
  - Write len=4 with TLAST on data 2 -> 2 writes, err_count+1, back in HDR.
  - Write len=1 with no TLAST until 2 flits later -> 1 write, remainder dropped, err_count+1.
- Assert reset during DATA after 1 of 3 writes -> outputs 0, err_count=0. After release, a fresh write packet completes correctly.
